// File: rtl/bus_interconnect.sv
// Shared-bus interconnect: round-robin arbitration, address decode, local error for unmapped addresses.
// Optional BUS_IC_TIMEOUT_EN adds a watchdog that terminates a slave transaction after TIMEOUT busy cycles.
package bus_if_types_pkg;
  typedef enum logic [1:0] {TSZ_BYTE = 2'd0, TSZ_HALF = 2'd1, TSZ_WORD = 2'd2} tsize_e;
  typedef enum logic [1:0] {TT_READ = 2'd0, TT_WRITE = 2'd1, TT_IFETCH = 2'd2} ttype_e;
endpackage

module bus_interconnect
  import bus_if_types_pkg::*;
#(
  parameter int                         N_MASTERS  = 2,
  parameter int                         N_SLAVES   = 4,
  parameter logic [N_SLAVES-1:0][31:0]  SLAVE_BASE = '0,
  parameter logic [N_SLAVES-1:0][31:0]  SLAVE_MASK = '0,
  parameter int                         TIMEOUT    = 255
) (
  input  logic                          bclk,
  input  logic                          brst_n,
  input  logic [N_MASTERS-1:0]          m_breq,
  output logic [N_MASTERS-1:0]          m_bgnt,
  input  logic [N_MASTERS-1:0]          m_bstart,
  input  logic [N_MASTERS-1:0][31:0]    m_addr,
  input  logic [N_MASTERS-1:0][31:0]    m_wdata,
  input  tsize_e [N_MASTERS-1:0]        m_tsize,
  input  ttype_e [N_MASTERS-1:0]        m_ttype,
  output logic [N_MASTERS-1:0][31:0]    m_rdata,
  output logic [N_MASTERS-1:0]          m_bdone,
  output logic [N_MASTERS-1:0]          m_berror,
  output logic [N_SLAVES-1:0]           s_ss,
  output logic                          s_bstart,
  output logic [31:0]                   s_addr,
  output logic [31:0]                   s_wdata,
  output tsize_e                        s_tsize,
  output ttype_e                        s_ttype,
  input  logic [N_SLAVES-1:0][31:0]     s_rdata,
  input  logic [N_SLAVES-1:0]           s_bdone,
  input  logic [N_SLAVES-1:0]           s_berror
);

  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  if (N_MASTERS < 1 || N_MASTERS > 8 || N_SLAVES < 1 || N_SLAVES > 16 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("bus_interconnect: parameter out of range");
  end

  logic [1:0]    state_q, state_d;
  logic [MW-1:0] owner_q, owner_d;
  logic [MW-1:0] rr_q, rr_d;
  logic [SW-1:0] sel_q, sel_d;

  logic          arb_hit;
  logic [MW-1:0] arb_idx;
  logic [MW-1:0] cand;
  logic          dec_hit;
  logic [SW-1:0] dec_idx;
  logic [MW-1:0] next_rr;
  logic          wd_expired;

  // First requester at or after rr_q, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = MW'((int'(rr_q) + i) % N_MASTERS);
      if (!arb_hit && m_breq[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Scanned high to low so the lowest matching slave index wins on overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int j = N_SLAVES - 1; j >= 0; j--) begin
      if ((m_addr[owner_q] & SLAVE_MASK[j]) == SLAVE_BASE[j]) begin
        dec_hit = 1'b1;
        dec_idx = SW'(j);
      end
    end
  end

  assign next_rr = (int'(owner_q) == N_MASTERS - 1) ? '0 : owner_q + 1'b1;

`ifdef BUS_IC_TIMEOUT_EN
  logic [15:0] wd_q;

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      wd_q <= '0;
    end else if (state_q != S_BUSY) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 16'd1;
    end
  end

  assign wd_expired = (state_q == S_BUSY) && (wd_q == 16'(TIMEOUT - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          owner_d = arb_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (m_bstart[owner_q]) begin
          if (dec_hit) begin
            sel_d   = dec_idx;
            state_d = S_BUSY;
          end else begin
            state_d = S_ERR;
          end
        end else if (!m_breq[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // A done in the same cycle as the watchdog expiry completes normally.
        if (s_bdone[sel_q]) begin
          state_d = S_IDLE;
          rr_d    = next_rr;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_IDLE;
        rr_d    = next_rr;
      end
    endcase
  end

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    m_bgnt   = '0;
    m_rdata  = '0;
    m_bdone  = '0;
    m_berror = '0;
    s_ss     = '0;
    s_bstart = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_tsize  = TSZ_BYTE;
    s_ttype  = TT_READ;
    if (state_q != S_IDLE) begin
      m_bgnt[owner_q] = 1'b1;
      s_addr  = m_addr[owner_q];
      s_wdata = m_wdata[owner_q];
      s_tsize = m_tsize[owner_q];
      s_ttype = m_ttype[owner_q];
    end
    case (state_q)
      S_GRANT: begin
        s_bstart = m_bstart[owner_q];
        if (m_bstart[owner_q] && dec_hit) s_ss[dec_idx] = 1'b1;
      end
      S_BUSY: begin
        s_ss[sel_q]       = 1'b1;
        m_rdata[owner_q]  = s_rdata[sel_q];
        m_bdone[owner_q]  = s_bdone[sel_q];
        m_berror[owner_q] = s_berror[sel_q];
      end
      S_ERR: begin
        m_bdone[owner_q]  = 1'b1;
        m_berror[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: 2 masters, 4 slaves with one overlapping region.
module tb_bus_interconnect;
  import bus_if_types_pkg::*;

  logic              bclk;
  logic              brst_n;
  logic [1:0]        m_breq, m_bgnt, m_bstart, m_bdone, m_berror;
  logic [1:0][31:0]  m_addr, m_wdata, m_rdata;
  tsize_e [1:0]      m_tsize;
  ttype_e [1:0]      m_ttype;
  logic [3:0]        s_ss;
  logic              s_bstart;
  logic [31:0]       s_addr, s_wdata;
  tsize_e            s_tsize;
  ttype_e            s_ttype;
  logic [3:0][31:0]  s_rdata;
  logic [3:0]        s_bdone, s_berror;

  int n_chk = 0;
  int n_fail = 0;

  // slave0 0x0000xxxx, slave1 0x1xxxxxxx, slave2 0x2000xxxx, slave3 0x2xxxxxxx (overlaps slave2)
  bus_interconnect #(
    .N_MASTERS (2),
    .N_SLAVES  (4),
    .SLAVE_BASE({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_0000}),
    .TIMEOUT   (16)
  ) dut (
    .bclk(bclk), .brst_n(brst_n),
    .m_breq(m_breq), .m_bgnt(m_bgnt), .m_bstart(m_bstart),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_tsize(m_tsize), .m_ttype(m_ttype),
    .m_rdata(m_rdata), .m_bdone(m_bdone), .m_berror(m_berror),
    .s_ss(s_ss), .s_bstart(s_bstart), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_tsize(s_tsize), .s_ttype(s_ttype),
    .s_rdata(s_rdata), .s_bdone(s_bdone), .s_berror(s_berror)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge bclk);
    #1;
  endtask

  task automatic clear_inputs;
    m_breq = '0; m_bstart = '0; m_addr = '0; m_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      m_tsize[i] = TSZ_BYTE;
      m_ttype[i] = TT_READ;
    end
    s_rdata = '0; s_bdone = '0; s_berror = '0;
  endtask

  task automatic apply_reset;
    brst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge bclk);
    #3 brst_n = 1'b1;
  endtask

  task automatic test_reset;
    brst_n = 1'b0;
    clear_inputs();
    m_breq = 2'b11; m_addr[0] = 32'h1000_0000; m_wdata[0] = 32'h5555_AAAA;
    repeat (3) @(posedge bclk);
    #1;
    n_chk++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL rst_bgnt: got %b want 00", m_bgnt); end
    n_chk++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL rst_ss: got %b want 0000", s_ss); end
    n_chk++; if (s_bstart !== 1'b0) begin n_fail++; $display("FAIL rst_bstart: got %b want 0", s_bstart); end
    n_chk++; if ({m_bdone, m_berror} !== 4'b0000) begin n_fail++; $display("FAIL rst_done_err: got %b want 0000", {m_bdone, m_berror}); end
    n_chk++; if (m_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", m_rdata); end
    n_chk++; if ({s_addr, s_wdata} !== 64'h0) begin n_fail++; $display("FAIL rst_sbus: got %h want 0", {s_addr, s_wdata}); end
    clear_inputs();
    #2 brst_n = 1'b1;
  endtask

  task automatic test_single_read;
    m_breq = 2'b01; m_addr[0] = 32'h1000_0040; m_tsize[0] = TSZ_WORD; m_ttype[0] = TT_READ;
    #1;
    n_chk++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL sr_cycle0_gnt: got %b want 00", m_bgnt); end
    tick();
    m_bstart = 2'b01; #1;
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL sr_gnt: got %b want 01", m_bgnt); end
    n_chk++; if (s_ss !== 4'b0010) begin n_fail++; $display("FAIL sr_ss_start: got %b want 0010", s_ss); end
    n_chk++; if (s_bstart !== 1'b1) begin n_fail++; $display("FAIL sr_bstart: got %b want 1", s_bstart); end
    n_chk++; if (s_addr !== 32'h1000_0040) begin n_fail++; $display("FAIL sr_addr: got %h want 10000040", s_addr); end
    n_chk++; if (s_tsize !== TSZ_WORD) begin n_fail++; $display("FAIL sr_tsize: got %0d want %0d", s_tsize, TSZ_WORD); end
    tick();
    m_bstart = 2'b00; s_bdone[2] = 1'b1; #1;
    n_chk++; if (s_ss !== 4'b0010) begin n_fail++; $display("FAIL sr_ss_busy: got %b want 0010", s_ss); end
    n_chk++; if (s_bstart !== 1'b0) begin n_fail++; $display("FAIL sr_bstart_busy: got %b want 0", s_bstart); end
    n_chk++; if (m_bdone !== 2'b00) begin n_fail++; $display("FAIL sr_unsel_done: got %b want 00", m_bdone); end
    tick();
    s_bdone = '0; #1;
    tick();
    s_bdone[1] = 1'b1; s_rdata[1] = 32'hDEAD_BEEF; #1;
    n_chk++; if (m_bdone !== 2'b01) begin n_fail++; $display("FAIL sr_done: got %b want 01", m_bdone); end
    n_chk++; if (m_rdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sr_rdata: got %h want deadbeef", m_rdata[0]); end
    n_chk++; if (m_rdata[1] !== 32'h0) begin n_fail++; $display("FAIL sr_rdata_other: got %h want 0", m_rdata[1]); end
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL sr_gnt_done: got %b want 01", m_bgnt); end
    tick();
    s_bdone = '0; s_rdata = '0; m_breq = 2'b00; #1;
    n_chk++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL sr_gnt_drop: got %b want 00", m_bgnt); end
    n_chk++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL sr_ss_drop: got %b want 0000", s_ss); end
  endtask

  task automatic test_round_robin;
    apply_reset();
    m_breq = 2'b11; m_addr[0] = 32'h0000_0010; m_addr[1] = 32'h2000_0004;
    tick();
    m_bstart = 2'b01; #1;
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL rr_first_m0: got %b want 01", m_bgnt); end
    n_chk++; if (s_ss !== 4'b0001) begin n_fail++; $display("FAIL rr_ss0: got %b want 0001", s_ss); end
    tick();
    m_bstart = 2'b00; s_bdone[0] = 1'b1; #1;
    n_chk++; if (m_bdone !== 2'b01) begin n_fail++; $display("FAIL rr_zero_wait_done: got %b want 01", m_bdone); end
    tick();
    s_bdone = '0; #1;
    n_chk++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL rr_idle_gap: got %b want 00", m_bgnt); end
    tick();
    m_bstart = 2'b10; #1;
    n_chk++; if (m_bgnt !== 2'b10) begin n_fail++; $display("FAIL rr_second_m1: got %b want 10", m_bgnt); end
    n_chk++; if (s_ss !== 4'b0100) begin n_fail++; $display("FAIL rr_overlap_low: got %b want 0100", s_ss); end
    n_chk++; if (s_addr !== 32'h2000_0004) begin n_fail++; $display("FAIL rr_addr_m1: got %h want 20000004", s_addr); end
    tick();
    m_bstart = 2'b00; s_bdone[2] = 1'b1; #1;
    n_chk++; if (m_bdone !== 2'b10) begin n_fail++; $display("FAIL rr_done_m1: got %b want 10", m_bdone); end
    tick();
    s_bdone = '0; #1;
    tick();
    m_breq = 2'b00; #1;
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL rr_third_m0: got %b want 01", m_bgnt); end
    tick();
    n_chk++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL rr_release: got %b want 00", m_bgnt); end
    m_breq = 2'b11;
    tick();
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL rr_ptr_kept: got %b want 01", m_bgnt); end
    m_breq = 2'b00;
    tick();
  endtask

  task automatic test_unmapped;
    m_breq = 2'b10; m_addr[1] = 32'hFFFF_0000;
    tick();
    m_bstart = 2'b10; #1;
    n_chk++; if (m_bgnt !== 2'b10) begin n_fail++; $display("FAIL um_gnt: got %b want 10", m_bgnt); end
    n_chk++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL um_ss_start: got %b want 0000", s_ss); end
    n_chk++; if (s_bstart !== 1'b1) begin n_fail++; $display("FAIL um_bstart: got %b want 1", s_bstart); end
    tick();
    m_bstart = 2'b00; m_breq = 2'b00; #1;
    n_chk++; if ({m_bdone, m_berror} !== 4'b1010) begin n_fail++; $display("FAIL um_err: got %b want 1010", {m_bdone, m_berror}); end
    n_chk++; if (m_rdata !== 64'h0) begin n_fail++; $display("FAIL um_rdata: got %h want 0", m_rdata); end
    n_chk++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL um_ss_err: got %b want 0000", s_ss); end
    tick();
    n_chk++; if ({m_bdone, m_berror, m_bgnt} !== 6'b0) begin n_fail++; $display("FAIL um_after: got %b want 000000", {m_bdone, m_berror, m_bgnt}); end
  endtask

  task automatic test_slave_error;
    m_breq = 2'b11; m_addr[0] = 32'h2100_0000; m_addr[1] = 32'h0;
    tick();
    m_bstart = 2'b01; #1;
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL se_gnt: got %b want 01", m_bgnt); end
    n_chk++; if (s_ss !== 4'b1000) begin n_fail++; $display("FAIL se_ss3: got %b want 1000", s_ss); end
    tick();
    m_bstart = 2'b00; s_bdone[3] = 1'b1; s_berror[3] = 1'b1; s_rdata[3] = 32'h1234_5678; #1;
    n_chk++; if (m_berror !== 2'b01) begin n_fail++; $display("FAIL se_berror_owner: got %b want 01", m_berror); end
    n_chk++; if (m_bdone !== 2'b01) begin n_fail++; $display("FAIL se_bdone_owner: got %b want 01", m_bdone); end
    n_chk++; if (m_rdata[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL se_rdata: got %h want 12345678", m_rdata[0]); end
    n_chk++; if (m_rdata[1] !== 32'h0) begin n_fail++; $display("FAIL se_rdata_other: got %h want 0", m_rdata[1]); end
    tick();
    s_bdone = '0; s_berror = '0; s_rdata = '0; m_breq = 2'b00; #1;
    n_chk++; if (m_berror !== 2'b00) begin n_fail++; $display("FAIL se_after: got %b want 00", m_berror); end
  endtask

  task automatic test_reset_busy;
    m_breq = 2'b11; m_addr[1] = 32'h1000_0000;
    tick();
    m_bstart = 2'b10; #1;
    n_chk++; if (m_bgnt !== 2'b10) begin n_fail++; $display("FAIL rb_gnt_m1: got %b want 10", m_bgnt); end
    tick();
    m_bstart = 2'b00; s_bdone[1] = 1'b1; #1;
    n_chk++; if (m_bdone !== 2'b10) begin n_fail++; $display("FAIL rb_pre_done: got %b want 10", m_bdone); end
    brst_n = 1'b0; #1;
    n_chk++; if ({m_bgnt, m_bdone, m_berror} !== 6'b0) begin n_fail++; $display("FAIL rb_outs: got %b want 000000", {m_bgnt, m_bdone, m_berror}); end
    n_chk++; if (s_ss !== 4'b0000) begin n_fail++; $display("FAIL rb_ss: got %b want 0000", s_ss); end
    n_chk++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL rb_saddr: got %h want 0", s_addr); end
    #2 brst_n = 1'b1; s_bdone = '0;
    tick();
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL rb_next_m0: got %b want 01", m_bgnt); end
    m_breq = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back;
    m_breq = 2'b01; m_addr[0] = 32'h0000_0100; m_wdata[0] = 32'hCAFE_F00D;
    m_ttype[0] = TT_WRITE; m_tsize[0] = TSZ_HALF;
    tick();
    m_bstart = 2'b01; #1;
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL bb_gnt1: got %b want 01", m_bgnt); end
    n_chk++; if (s_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bb_wdata: got %h want cafef00d", s_wdata); end
    n_chk++; if (s_ttype !== TT_WRITE) begin n_fail++; $display("FAIL bb_ttype: got %0d want %0d", s_ttype, TT_WRITE); end
    n_chk++; if (s_tsize !== TSZ_HALF) begin n_fail++; $display("FAIL bb_tsize: got %0d want %0d", s_tsize, TSZ_HALF); end
    tick();
    m_bstart = 2'b00; s_bdone[0] = 1'b1; #1;
    n_chk++; if ({m_bgnt, m_bdone} !== 4'b0101) begin n_fail++; $display("FAIL bb_done1: got %b want 0101", {m_bgnt, m_bdone}); end
    tick();
    s_bdone = '0; #1;
    n_chk++; if (m_bgnt !== 2'b00) begin n_fail++; $display("FAIL bb_gap: got %b want 00", m_bgnt); end
    n_chk++; if (s_wdata !== 32'h0) begin n_fail++; $display("FAIL bb_wdata_idle: got %h want 0", s_wdata); end
    tick();
    m_bstart = 2'b01; #1;
    n_chk++; if (m_bgnt !== 2'b01) begin n_fail++; $display("FAIL bb_gnt2: got %b want 01", m_bgnt); end
    tick();
    m_bstart = 2'b00; s_bdone[0] = 1'b1; #1;
    n_chk++; if (m_bdone !== 2'b01) begin n_fail++; $display("FAIL bb_done2: got %b want 01", m_bdone); end
    tick();
    clear_inputs(); #1;
  endtask

  initial begin
    clear_inputs();
    brst_n = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_unmapped();
    test_slave_error();
    test_reset_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
